// File: rtl/axi_pkg.sv
// Shared AXI constants, bridge FSM state type and SRAM-size to AXI helpers.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_AR,
        S_RD_R,
        S_WR_AW_W,
        S_WR_B
    } bridge_state_t;

    // Size code 3 has no AXI meaning here; it is handled as a full word.
    function automatic logic [1:0] map_size(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

    function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << addr_lo;
            2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/d_sram_axi_bridge.sv
// SRAM-like data-cache port to AXI3 master, one outstanding single-beat transaction.
// Minimum latency 2 cycles req-to-data_ok; upstream is stalled (no addr_ok) while busy.
module d_sram_axi_bridge
    import axi_pkg::*;
#(
    parameter int unsigned         ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0] RD_ID    = '0,
    parameter logic [ID_WIDTH-1:0] WR_ID    = ID_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_wdata,
    output logic [31:0]         data_rdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic                bus_err,
    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [3:0]          arlen,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [ID_WIDTH-1:0] awid,
    output logic [31:0]         awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    bridge_state_t r_state, w_next;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic [1:0]    r_size;
    logic          r_aw_done, r_w_done;
    logic          w_unused_rlast;

    // Only single-beat bursts are issued, so the last flag carries no information.
    assign w_unused_rlast = rlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= '0;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && data_req) begin
                r_addr    <= data_addr;
                r_wdata   <= data_wdata;
                r_size    <= data_size;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (awvalid && awready) r_aw_done <= 1'b1;
            if (wvalid && wready)   r_w_done  <= 1'b1;
            if (r_state == S_RD_R && rvalid) r_rdata <= rdata;
        end
    end

    always_comb begin
        w_next       = r_state;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = r_rdata;
        bus_err      = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                data_addr_ok = data_req & ~rst;
                if (data_req) w_next = data_wr ? S_WR_AW_W : S_RD_AR;
            end
            S_RD_AR: begin
                arvalid = 1'b1;
                if (arready) w_next = S_RD_R;
            end
            S_RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_data_ok = 1'b1;
                    data_rdata   = rdata;
                    bus_err      = (rresp != RESP_OKAY);
                    w_next       = S_IDLE;
                end
            end
            S_WR_AW_W: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                // A pending channel completes this cycle if its ready is high.
                if ((r_aw_done | awready) && (r_w_done | wready)) w_next = S_WR_B;
            end
            S_WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_data_ok = 1'b1;
                    bus_err      = (bresp != RESP_OKAY);
                    w_next       = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign arid   = RD_ID;
    assign araddr = r_addr;
    assign arlen  = 4'd0;
    assign arsize = {1'b0, map_size(r_size)};
    assign awid   = WR_ID;
    assign awaddr = r_addr;
    assign awlen  = 4'd0;
    assign awsize = {1'b0, map_size(r_size)};
    assign wdata  = r_wdata;
    assign wstrb  = size_to_wstrb(r_size, r_addr[1:0]);
    assign wlast  = 1'b1;

endmodule
